// File: rtl/hdmi_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdmi_fetch_ctrl : per-line chunked burst read scheduler, DDR -> HDMI FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module hdmi_fetch_ctrl #(
   parameter int ADDR_W        = 32,
   parameter int CHUNK_PIX     = 64,
   parameter int BYTES_PER_PIX = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic [10:0]       hres,
   input  logic [9:0]        vres,
   input  logic              read_go,
   input  logic              read_next_line,
   input  logic              read_done,
   input  logic [9:0]        fifo_free,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_len,
   input  logic              rd_ack,
   output logic              busy,
   output logic              line_late,
   output logic [15:0]       frame_cnt
);

   localparam int         C_CHUNK_SH  = $clog2(CHUNK_PIX);
   localparam logic [7:0] C_CHUNK_LEN = 8'(CHUNK_PIX);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_ACK  = 3'd3,
      S_WAIT_LINE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
   logic [ADDR_W-1:0]   chunk_addr_q, chunk_addr_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [10:0]         nchunks_q, nchunks_d;
   logic [10:0]         chunks_left_q, chunks_left_d;
   logic [10:0]         lines_issued_q, lines_issued_d;
   logic [9:0]          vres_q, vres_d;
   logic [7:0]          last_len_q, last_len_d;
   logic                pending_q, pending_d;
   logic                done_q, done_d;
   logic                line_late_q, line_late_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic                rd_req_q, rd_req_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [7:0]          rd_len_q, rd_len_d;

   logic                w_exit;
   logic [7:0]          w_len;
   logic [7:0]          w_rem;
   logic [10:0]         w_nchunks;
   logic [ADDR_W-1:0]   w_stride;
   logic [ADDR_W-1:0]   w_step;

   // CHUNK_PIX is a power of two, so ceil/mod reduce to shift and mask
   assign w_nchunks = 11'((12'(hres) + 12'(CHUNK_PIX - 1)) >> C_CHUNK_SH);
   assign w_rem     = 8'(hres & 11'(CHUNK_PIX - 1));
   assign w_stride  = ADDR_W'(hres) * ADDR_W'(BYTES_PER_PIX);
   assign w_step    = ADDR_W'(rd_len_q) * ADDR_W'(BYTES_PER_PIX);
   assign w_exit    = read_done | ~enable;
   assign w_len     = (chunks_left_q == 11'd1) ? last_len_q : C_CHUNK_LEN;

   always_comb begin
      state_d        = state_q;
      line_addr_d    = line_addr_q;
      chunk_addr_d   = chunk_addr_q;
      stride_d       = stride_q;
      nchunks_d      = nchunks_q;
      chunks_left_d  = chunks_left_q;
      lines_issued_d = lines_issued_q;
      vres_d         = vres_q;
      last_len_d     = last_len_q;
      pending_d      = pending_q;
      done_d         = done_q;
      line_late_d    = line_late_q;
      frame_cnt_d    = frame_cnt_q;
      rd_req_d       = rd_req_q;
      rd_addr_d      = rd_addr_q;
      rd_len_d       = rd_len_q;

      if (read_done) frame_cnt_d = frame_cnt_q + 16'd1;

      // an early line request is remembered once; read_done wins a same-cycle tie
      if (read_next_line && !read_done &&
          (state_q == S_LOAD || state_q == S_ISSUE || state_q == S_WAIT_ACK)) begin
         pending_d   = 1'b1;
         line_late_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (read_go && enable) begin
               line_addr_d    = fb_base;
               lines_issued_d = 11'd0;
               stride_d       = w_stride;
               nchunks_d      = w_nchunks;
               last_len_d     = (w_rem == 8'd0) ? C_CHUNK_LEN : w_rem;
               vres_d         = vres;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_exit) begin
               state_d   = S_IDLE;
               pending_d = 1'b0;
            end else begin
               chunk_addr_d   = line_addr_q;
               chunks_left_d  = nchunks_q;
               lines_issued_d = lines_issued_q + 11'd1;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_exit) begin
               state_d   = S_IDLE;
               pending_d = 1'b0;
            end else if (chunks_left_q == 11'd0) begin
               state_d = S_WAIT_LINE;
            end else if ({2'b00, w_len} <= fifo_free) begin
               rd_req_d  = 1'b1;
               rd_addr_d = chunk_addr_q;
               rd_len_d  = w_len;
               state_d   = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (w_exit) done_d = 1'b1;
            if (rd_ack) begin
               rd_req_d      = 1'b0;
               chunk_addr_d  = chunk_addr_q + w_step;
               chunks_left_d = chunks_left_q - 11'd1;
               if (done_q || w_exit) begin
                  state_d   = S_IDLE;
                  pending_d = 1'b0;
                  done_d    = 1'b0;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_WAIT_LINE: begin
            if (w_exit) begin
               state_d   = S_IDLE;
               pending_d = 1'b0;
            end else if (pending_q || read_next_line) begin
               pending_d   = 1'b0;
               line_addr_d = line_addr_q + stride_q;
               if (lines_issued_q < {1'b0, vres_q}) state_d = S_LOAD;
            end
         end
         default: begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            done_d    = 1'b0;
            rd_req_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         line_addr_q    <= '0;
         chunk_addr_q   <= '0;
         stride_q       <= '0;
         nchunks_q      <= '0;
         chunks_left_q  <= '0;
         lines_issued_q <= '0;
         vres_q         <= '0;
         last_len_q     <= '0;
         pending_q      <= 1'b0;
         done_q         <= 1'b0;
         line_late_q    <= 1'b0;
         frame_cnt_q    <= '0;
         rd_req_q       <= 1'b0;
         rd_addr_q      <= '0;
         rd_len_q       <= '0;
      end else begin
         state_q        <= state_d;
         line_addr_q    <= line_addr_d;
         chunk_addr_q   <= chunk_addr_d;
         stride_q       <= stride_d;
         nchunks_q      <= nchunks_d;
         chunks_left_q  <= chunks_left_d;
         lines_issued_q <= lines_issued_d;
         vres_q         <= vres_d;
         last_len_q     <= last_len_d;
         pending_q      <= pending_d;
         done_q         <= done_d;
         line_late_q    <= line_late_d;
         frame_cnt_q    <= frame_cnt_d;
         rd_req_q       <= rd_req_d;
         rd_addr_q      <= rd_addr_d;
         rd_len_q       <= rd_len_d;
      end
   end

   assign rd_req    = rd_req_q;
   assign rd_addr   = rd_addr_q;
   assign rd_len    = rd_len_q;
   assign busy      = (state_q != S_IDLE);
   assign line_late = line_late_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
